convolutional_interleaver: RTL

Byte-wide convolutional (Forney) interleaver, I=12 branches, branch delay unit M=17, matching DVB outer interleaving. It is the transmit-side counterpart of the deinterleaver in this design. Branch b delays its bytes by b·M branch visits, and the deinterleaver compensates with (I−1−b)·M. It sits between the RS(204,188) encoder output and the inner coder, and adds valid/sync handling so it can run on a gapped byte stream.

---
 rtl/convolutional_interleaver_if.sv | 23 ++
 rtl/convolutional_interleaver.sv | 102 ++++++++++
 2 files changed

// File: rtl/convolutional_interleaver_if.sv
// Byte-stream bus between the transmit chain and the convolutional interleaver.
// The master drives the input side; the interleaver (slave) drives the output side.
interface convolutional_interleaver_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_sync;
   logic [WIDTH-1:0] interleaver_input;
   logic             out_valid;
   logic [WIDTH-1:0] interleaver_output;
   logic [3:0]       select;
   logic             sync_err;

   modport master (
      output in_valid, in_sync, interleaver_input,
      input  out_valid, interleaver_output, select, sync_err
   );

   modport slave (
      input  in_valid, in_sync, interleaver_input,
      output out_valid, interleaver_output, select, sync_err
   );
endinterface

// File: rtl/convolutional_interleaver.sv
// Forney convolutional interleaver (I branches, M bytes per branch step) on a gapped byte stream.
// All branch FIFOs share one packed memory; branch 0 bypasses it through a register.
module convolutional_interleaver #(
   parameter int BRANCHES   = 12,
   parameter int DEPTH_UNIT = 17,
   parameter int WIDTH      = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   convolutional_interleaver_if.slave  bus
);
   localparam int MEM_SIZE = DEPTH_UNIT * BRANCHES * (BRANCHES - 1) / 2;
   localparam int AW       = 11;
   localparam int PW       = 8;
   localparam int BW       = 4;

   function automatic logic [AW-1:0] base_of(input logic [BW-1:0] b);
      int bi;
      bi = int'(b);
      return AW'(DEPTH_UNIT * bi * (bi - 1) / 2);
   endfunction

   function automatic logic [PW-1:0] ptr_last(input logic [BW-1:0] b);
      return PW'(int'(b) * DEPTH_UNIT - 1);
   endfunction

   logic [WIDTH-1:0]    mem [0:MEM_SIZE-1];
   logic [WIDTH-1:0]    rd_data;
   logic [WIDTH-1:0]    byp;
   logic [BW-1:0]       br;
   logic [BW-1:0]       sel;
   logic [PW-1:0]       ptr [0:BRANCHES-1];
   logic [BRANCHES-1:0] primed;
   logic                primed_q;
   logic                out_valid_q;
   logic                sync_err_q;

   logic                is_realign;
   logic [BW-1:0]       eff;
   logic [BW-1:0]       br_next;
   logic [PW-1:0]       ptr_cur;
   logic                ptr_wrap;
   logic [AW-1:0]       mem_addr;
   logic                mem_we;

   // A sync byte off branch 0 is forced onto branch 0 so the commutator realigns.
   always_comb begin
      is_realign = bus.in_valid && bus.in_sync && (br != '0);
      eff        = is_realign ? '0 : br;
      br_next    = (eff == BW'(BRANCHES - 1)) ? '0 : eff + 1'b1;
      ptr_cur    = ptr[eff];
      ptr_wrap   = (ptr_cur == ptr_last(eff));
      mem_addr   = base_of(eff) + AW'(ptr_cur);
      mem_we     = bus.in_valid && (eff != '0);
   end

   // Read-before-write on the same address: rd_data gets the byte stored one lap ago.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         rd_data       <= mem[mem_addr];
         mem[mem_addr] <= bus.interleaver_input;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         br          <= '0;
         sel         <= '0;
         byp         <= '0;
         primed      <= '0;
         primed_q    <= 1'b0;
         out_valid_q <= 1'b0;
         sync_err_q  <= 1'b0;
         for (int i = 0; i < BRANCHES; i++) begin
            ptr[i] <= '0;
         end
      end else begin
         out_valid_q <= bus.in_valid;
         sync_err_q  <= is_realign;
         if (bus.in_valid) begin
            br  <= br_next;
            sel <= eff;
            if (eff == '0) begin
               byp <= bus.interleaver_input;
            end else begin
               ptr[eff] <= ptr_wrap ? '0 : ptr_cur + 1'b1;
               // Flag sampled before the wrap update: the wrapping visit still reads stale memory.
               primed_q <= primed[eff];
               if (ptr_wrap) begin
                  primed[eff] <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.out_valid          = out_valid_q;
   assign bus.sync_err           = sync_err_q;
   assign bus.select             = sel;
   assign bus.interleaver_output = (sel == '0) ? byp : (primed_q ? rd_data : '0);

endmodule
